timer_digit_loader: RTL and testbench
=====================================

// Module: timer_digit_loader
// PURPOSE
//  Consumes keypad digits and the saturation flag of the upstream non-recycling counter, and assembles
//  the cooking-time entry as packed BCD (M:SS). Sits between the keypad priority encoder and the countdown timer.
//  Accepts one digit per key press, shifts digits in from the right, and hands the value to the timer on start.
// PARAMETERS
//  NUM_DIGITS   3   BCD digits held (min_ones, sec_tens, sec_ones); range 2..4
//  DIGIT_W      4   width of one BCD digit
// PORTS
//  clock         in   1            single system clock, all logic on posedge
//  clear         in   1            synchronous, active-high reset
//  entry_enable  in   1            load window open (saturated output of the upstream non-recycling counter)
//  key_valid     in   1            a key is currently pressed (level, from the priority encoder)
//  key_digit     in   DIGIT_W      encoded key value; 0..9 are digits, 10..15 are ignored
//  start         in   1            request to hand the entry to the timer (level)
//  time_bcd      out  NUM_DIGITS*DIGIT_W  entered time, [DIGIT_W-1:0] = sec_ones
//  digit_count   out  3            digits accepted since the last clear/load (0..NUM_DIGITS)
//  time_loaded   out  1            one-cycle pulse: time_bcd is valid for the timer
//  entry_full    out  1            NUM_DIGITS digits held; further digits ignored
// BEHAVIOUR
//  - Reset: when clear is high at a clock edge, time_bcd=0, digit_count=0, time_loaded=0, entry_full=0,
//    key_q=0, and state=IDLE. Clear wins over every other input in the same cycle.
//  - Press detect: key_q registers key_valid; accept = key_valid & ~key_q (rising edge) & entry_enable & key_digit<=9.
//    A held key gives exactly one accept. A press that rises while entry_enable=0 is lost, even if
//    entry_enable goes high while the key is still held.
//  - Accept (latency 1): time_bcd <= {time_bcd[(NUM_DIGITS-1)*DIGIT_W-1:0], key_digit};
//    digit_count increments, saturating at NUM_DIGITS.
//  - FSM states: IDLE, ENTRY, FULL, LOAD.
//      IDLE->ENTRY on the first accept; ENTRY->FULL when an accept brings digit_count to NUM_DIGITS;
//      ENTRY/FULL->LOAD when start is high and digit_count>0; LOAD->IDLE after exactly 1 cycle.
//      In IDLE, start is ignored (nothing to load), so an empty entry never produces time_loaded.
//  - LOAD: time_loaded=1 for that cycle. time_bcd holds the entered value during LOAD.
//    On LOAD->IDLE, time_bcd and digit_count are zeroed.
//  - FULL: entry_full=1; accepts are discarded and time_bcd does not change.
//  - Simultaneous accept and start in ENTRY: start has priority; the digit is dropped and the FSM goes to LOAD.
//  - A key held across LOAD/IDLE is not re-accepted; it must be released first.
// CONFIGURATION
//  SECONDS_CLAMP_EN defined: on entry to LOAD, if sec_tens>5, the loaded value has sec_tens=5 and
//    sec_ones=9 (seconds clamp to 59). The clamped value is what time_bcd shows during the LOAD cycle.
//  SECONDS_CLAMP_EN undefined: digits are passed through unchanged; the timer handles any value.
// STRUCTURE
//  - Shared package timer_entry_pkg holds: the state typedef (IDLE/ENTRY/FULL/LOAD), BCD_MAX_DIGIT=9,
//    SEC_TENS_MAX=5, DIGIT_W.
//  - One sub-module, key_edge_detector (key_q register and rising-edge accept qualification),
//    which the timer-start path reuses.
//  - Digit shift register, counter and FSM stay in this module.
// TESTING
//  1. Reset, then entry_enable=1 and press 1, 2, 3 (each held 3 cycles)
//     -> time_bcd=0x123, digit_count=3, entry_full=1.
//  2. Full entry 0x123, then press 7 -> time_bcd stays 0x123; then start=1
//     -> one cycle later time_loaded=1 for 1 cycle, then time_bcd=0, state IDLE.
//  3. entry_enable=0, press 5; then raise entry_enable while the key is held -> no accept, digit_count=0.
//  4. Press key_digit=12 -> ignored. start=1 with empty entry -> time_loaded never asserts.
//  5. Press 4 then 8 (0x048), raise clear on the same cycle as start
//     -> all outputs 0 on the next cycle, time_loaded never pulses.
//  6. SECONDS_CLAMP_EN: enter 1, 7, 5, then start -> time_bcd=0x159 while time_loaded=1;
//     without the macro -> 0x175.

Source files
------------

// File: rtl/timer_entry_pkg.sv
// Shared types and constants for the cooking-time keypad entry path.
package timer_entry_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned CNT_W         = 3;
  localparam int unsigned BCD_MAX_DIGIT = 9;
  localparam int unsigned SEC_TENS_MAX  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    LOAD  = 2'd3
  } state_e;

endpackage : timer_entry_pkg

// File: rtl/timer_digit_loader_key_edge_detector.sv
// Registers the key level and qualifies its rising edge as a single digit accept.
module key_edge_detector #(
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned MAX_DIGIT = 9
) (
  input  logic               clk_i,
  input  logic               clear_i,
  input  logic               key_valid_i,
  input  logic               enable_i,
  input  logic [DIGIT_W-1:0] key_digit_i,
  output logic               accept_c_o
);

  logic key_q;
  logic key_d;

  assign key_d = key_valid_i;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_d;
    end
  end

  // A press that rises while the window is closed is never accepted later.
  assign accept_c_o = key_valid_i & ~key_q & enable_i &
                      (key_digit_i <= DIGIT_W'(MAX_DIGIT));

endmodule : key_edge_detector

// File: rtl/timer_digit_loader.sv
// Assembles keypad digits into packed BCD M:SS and hands it to the timer on start.
// Optional SECONDS_CLAMP_EN: clamps seconds to 59 when the value is loaded.
module timer_digit_loader #(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned DIGIT_W    = timer_entry_pkg::DIGIT_W
) (
  input  logic                          clock_i,
  input  logic                          clear_i,
  input  logic                          entry_enable_i,
  input  logic                          key_valid_i,
  input  logic [DIGIT_W-1:0]            key_digit_i,
  input  logic                          start_i,
  output logic [NUM_DIGITS*DIGIT_W-1:0] time_bcd_o,
  output logic [2:0]                    digit_count_o,
  output logic                          time_loaded_o,
  output logic                          entry_full_o
);

  import timer_entry_pkg::*;

  localparam int unsigned TIME_W = NUM_DIGITS * DIGIT_W;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              loaded_q, loaded_d;
  logic              full_q, full_d;

  logic              accept_c;
  logic [TIME_W-1:0] shifted_c;
  logic [TIME_W-1:0] load_value_c;
  logic [CNT_W-1:0]  count_inc_c;

  key_edge_detector #(
    .DIGIT_W   (DIGIT_W),
    .MAX_DIGIT (BCD_MAX_DIGIT)
  ) u_key_edge (
    .clk_i       (clock_i),
    .clear_i     (clear_i),
    .key_valid_i (key_valid_i),
    .enable_i    (entry_enable_i),
    .key_digit_i (key_digit_i),
    .accept_c_o  (accept_c)
  );

  assign shifted_c   = {time_q[TIME_W-DIGIT_W-1:0], key_digit_i};
  assign count_inc_c = count_q + CNT_W'(1);

`ifdef SECONDS_CLAMP_EN
  // Seconds above 59 become exactly 59; minutes pass through.
  always_comb begin
    load_value_c = time_q;
    if (time_q[2*DIGIT_W-1:DIGIT_W] > DIGIT_W'(SEC_TENS_MAX)) begin
      load_value_c[2*DIGIT_W-1:DIGIT_W] = DIGIT_W'(SEC_TENS_MAX);
      load_value_c[DIGIT_W-1:0]         = DIGIT_W'(BCD_MAX_DIGIT);
    end
  end
`else
  assign load_value_c = time_q;
`endif

  // Next-state, digit shift and counter; start outranks a same-cycle accept.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = ENTRY;
          time_d  = shifted_c;
          count_d = count_inc_c;
        end
      end
      ENTRY: begin
        if (start_i && (count_q != '0)) begin
          state_d = LOAD;
          time_d  = load_value_c;
        end else if (accept_c) begin
          time_d  = shifted_c;
          count_d = count_inc_c;
          if (count_inc_c == CNT_W'(NUM_DIGITS)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (start_i && (count_q != '0)) begin
          state_d = LOAD;
          time_d  = load_value_c;
        end
      end
      LOAD: begin
        state_d = IDLE;
        time_d  = '0;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        time_d  = '0;
        count_d = '0;
      end
    endcase

    loaded_d = (state_d == LOAD);
    full_d   = (state_d == FULL);
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      state_q  <= IDLE;
      time_q   <= '0;
      count_q  <= '0;
      loaded_q <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      full_q   <= full_d;
    end
  end

  assign time_bcd_o    = time_q;
  assign digit_count_o = count_q;
  assign time_loaded_o = loaded_q;
  assign entry_full_o  = full_q;

endmodule : timer_digit_loader

// File: tb/tb_timer_digit_loader.sv
// Self-checking bench for timer_digit_loader: per-cycle vector table plus start/load sequences.
module tb_timer_digit_loader;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned TIME_W     = NUM_DIGITS * DIGIT_W;

`ifdef SECONDS_CLAMP_EN
  localparam logic [TIME_W-1:0] EXP_175 = 12'h159;
  localparam logic [TIME_W-1:0] EXP_999 = 12'h959;
`else
  localparam logic [TIME_W-1:0] EXP_175 = 12'h175;
  localparam logic [TIME_W-1:0] EXP_999 = 12'h999;
`endif

  logic               clk = 1'b0;
  logic               clear;
  logic               ee;
  logic               kv;
  logic [DIGIT_W-1:0] kd;
  logic               st;
  logic [TIME_W-1:0]  time_bcd;
  logic [2:0]         digit_count;
  logic               time_loaded;
  logic               entry_full;

  always #5 clk = ~clk;

  timer_digit_loader #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) dut (
    .clock_i        (clk),
    .clear_i        (clear),
    .entry_enable_i (ee),
    .key_valid_i    (kv),
    .key_digit_i    (kd),
    .start_i        (st),
    .time_bcd_o     (time_bcd),
    .digit_count_o  (digit_count),
    .time_loaded_o  (time_loaded),
    .entry_full_o   (entry_full)
  );

  typedef struct {
    logic               clr;
    logic               ee;
    logic               kv;
    logic [DIGIT_W-1:0] kd;
    logic               st;
    logic [TIME_W-1:0]  et;
    logic [2:0]         ec;
    logic               el;
    logic               ef;
  } vec_t;

  typedef struct {
    int                idx;
    logic [TIME_W-1:0] et;
    logic [2:0]        ec;
    logic              el;
    logic              ef;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void v(input logic clr, input logic e, input logic k,
                            input logic [DIGIT_W-1:0] d, input logic s,
                            input logic [TIME_W-1:0] et, input logic [2:0] ec,
                            input logic el, input logic ef);
    vec_t r;
    r.clr = clr; r.ee = e; r.kv = k; r.kd = d; r.st = s;
    r.et = et; r.ec = ec; r.el = el; r.ef = ef;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
    end
  endtask

  // Scoreboard consumer: outputs settle just after the edge the vector was applied to.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("time_bcd",    e.idx, 32'(time_bcd),    32'(e.et));
      check("digit_count", e.idx, 32'(digit_count), 32'(e.ec));
      check("time_loaded", e.idx, 32'(time_loaded), 32'(e.el));
      check("entry_full",  e.idx, 32'(entry_full),  32'(e.ef));
    end
  end

  task automatic press(input logic [DIGIT_W-1:0] d);
    @(negedge clk);
    kv = 1'b1;
    kd = d;
    @(negedge clk);
    kv = 1'b0;
  endtask

  task automatic run_start(input int hold, input int cycles, output int pulses,
                           output logic [TIME_W-1:0] seen_t, output logic [2:0] seen_c);
    pulses = 0;
    seen_t = '0;
    seen_c = '0;
    @(negedge clk);
    st = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (time_loaded) begin
        pulses++;
        seen_t = time_bcd;
        seen_c = digit_count;
      end
      if (c == hold - 1) st = 1'b0;
    end
    st = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int                pulses;
    logic [TIME_W-1:0] seen_t;
    logic [2:0]        seen_c;

    clear = 1'b1; ee = 1'b0; kv = 1'b0; kd = '0; st = 1'b0;

    // clr ee kv kd st | time cnt loaded full (after the edge)
    v(1,0,0, 0,0, 12'h000,0,0,0);
    for (int r = 0; r < 3; r++) v(0,1,1,1,0, 12'h001,1,0,0);
    v(0,1,0, 0,0, 12'h001,1,0,0);
    for (int r = 0; r < 3; r++) v(0,1,1,2,0, 12'h012,2,0,0);
    v(0,1,0, 0,0, 12'h012,2,0,0);
    for (int r = 0; r < 3; r++) v(0,1,1,3,0, 12'h123,3,0,1);
    v(0,1,0, 0,0, 12'h123,3,0,1);
    // full: extra digit dropped, then load, then start ignored in IDLE
    v(0,1,1, 7,0, 12'h123,3,0,1);
    v(0,1,1, 7,0, 12'h123,3,0,1);
    v(0,1,0, 0,0, 12'h123,3,0,1);
    v(0,1,0, 0,1, 12'h123,3,1,0);
    v(0,1,0, 0,1, 12'h000,0,0,0);
    v(0,1,0, 0,1, 12'h000,0,0,0);
    v(0,1,0, 0,0, 12'h000,0,0,0);
    // press while window closed, window opens while held
    v(0,0,1, 5,0, 12'h000,0,0,0);
    v(0,1,1, 5,0, 12'h000,0,0,0);
    v(0,1,1, 5,0, 12'h000,0,0,0);
    v(0,1,0, 0,0, 12'h000,0,0,0);
    // non-digit key, start on empty entry
    v(0,1,1,12,0, 12'h000,0,0,0);
    v(0,1,0, 0,0, 12'h000,0,0,0);
    v(0,1,0, 0,1, 12'h000,0,0,0);
    v(0,1,0, 0,1, 12'h000,0,0,0);
    v(0,1,0, 0,0, 12'h000,0,0,0);
    // clear together with start
    v(0,1,1, 4,0, 12'h004,1,0,0);
    v(0,1,0, 0,0, 12'h004,1,0,0);
    v(0,1,1, 8,0, 12'h048,2,0,0);
    v(0,1,0, 0,0, 12'h048,2,0,0);
    v(1,1,0, 0,1, 12'h000,0,0,0);
    v(0,1,0, 0,0, 12'h000,0,0,0);
    v(0,1,0, 0,0, 12'h000,0,0,0);
    // 1,7,5 then load (clamped when the option is built in)
    v(0,1,1, 1,0, 12'h001,1,0,0);
    v(0,1,0, 0,0, 12'h001,1,0,0);
    v(0,1,1, 7,0, 12'h017,2,0,0);
    v(0,1,0, 0,0, 12'h017,2,0,0);
    v(0,1,1, 5,0, 12'h175,3,0,1);
    v(0,1,0, 0,0, 12'h175,3,0,1);
    v(0,1,0, 0,1, EXP_175,3,1,0);
    v(0,1,0, 0,0, 12'h000,0,0,0);
    // accept and start together, key held across LOAD/IDLE
    v(0,1,1, 9,0, 12'h009,1,0,0);
    v(0,1,0, 0,0, 12'h009,1,0,0);
    v(0,1,1, 6,1, 12'h009,1,1,0);
    v(0,1,1, 6,0, 12'h000,0,0,0);
    v(0,1,1, 6,0, 12'h000,0,0,0);
    v(0,1,0, 0,0, 12'h000,0,0,0);
    v(0,1,1, 6,0, 12'h006,1,0,0);
    v(1,1,1, 6,0, 12'h000,0,0,0);

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      clear = vecs[i].clr; ee = vecs[i].ee; kv = vecs[i].kv;
      kd    = vecs[i].kd;  st = vecs[i].st;
      e.idx = i; e.et = vecs[i].et; e.ec = vecs[i].ec;
      e.el  = vecs[i].el; e.ef = vecs[i].ef;
      sb_q.push_back(e);
    end
    @(negedge clk);
    clear = 1'b0; kv = 1'b0; st = 1'b0; ee = 1'b1;
    @(negedge clk);

    // Start held for several cycles on a partial entry gives one pulse.
    press(4'd2);
    press(4'd5);
    check("seqA_pre_time", 0, 32'(time_bcd), 32'h025);
    check("seqA_pre_cnt",  0, 32'(digit_count), 32'd2);
    run_start(5, 8, pulses, seen_t, seen_c);
    check("seqA_pulses",   0, 32'(pulses), 32'd1);
    check("seqA_load_val", 0, 32'(seen_t), 32'h025);
    check("seqA_load_cnt", 0, 32'(seen_c), 32'd2);
    @(negedge clk);
    check("seqA_post_time", 0, 32'(time_bcd), 32'h000);
    check("seqA_post_cnt",  0, 32'(digit_count), 32'd0);

    // Boundary keys: 10 ignored, 9 accepted; full 999 then load.
    press(4'd10);
    check("seqB_key10_cnt", 1, 32'(digit_count), 32'd0);
    press(4'd9);
    press(4'd9);
    press(4'd9);
    check("seqB_full_time", 1, 32'(time_bcd), 32'h999);
    check("seqB_full_flag", 1, 32'(entry_full), 32'd1);
    run_start(4, 6, pulses, seen_t, seen_c);
    check("seqB_pulses",   1, 32'(pulses), 32'd1);
    check("seqB_load_val", 1, 32'(seen_t), 32'(EXP_999));
    @(negedge clk);
    check("seqB_post_full", 1, 32'(entry_full), 32'd0);
    check("seqB_post_time", 1, 32'(time_bcd), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_timer_digit_loader
